// File: rtl/midi_uart_tx_pkg.sv
// Shared definitions for the MIDI OUT transmitter: default divider, frame size
// and transmitter state encodings.
package midi_uart_tx_pkg;

  localparam int unsigned MIDI_BAUD_DIV_1MHZ = 32;
  localparam int unsigned FRAME_BITS         = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/midi_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and flags the last
// cycle of each bit period. Shared with the MIDI receiver.
module midi_baud_tick #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Terminal compare stays explicit so non-power-of-two dividers wrap correctly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TERM) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign tick_c = en && (cnt == TERM);

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI OUT serialiser: single holding register feeding an 8N1 shifter, with
// 6850-style TDRE and sticky overrun status.
module midi_uart_tx
  import midi_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = MIDI_BAUD_DIV_1MHZ,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  ovr_clr,
  output logic                  tx,
  output logic                  tdre,
  output logic                  busy,
  output logic                  ovr
);

  localparam int unsigned BW = cnt_width(DATA_WIDTH);

  tx_state_e             state, state_d;
  logic [DATA_WIDTH-1:0] hold, hold_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic                  tx_d, tdre_d, busy_d, ovr_d;
  logic                  tick_c, restart_c, load_c;

  midi_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .en      (state != ST_IDLE),
    .tick_c  (tick_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      hold    <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tdre    <= 1'b1;
      busy    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_d;
      hold    <= hold_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
      tdre    <= tdre_d;
      busy    <= busy_d;
      ovr     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state;
    hold_d    = hold;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    tx_d      = tx;
    tdre_d    = tdre;
    busy_d    = busy;
    ovr_d     = ovr;
    restart_c = 1'b0;
    load_c    = 1'b0;

    // A dropped write outranks a same-cycle clear.
    if (ovr_clr) ovr_d = 1'b0;
    if (wr) begin
      if (tdre) begin
        hold_d = din;
        tdre_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (!tdre) load_c = 1'b1;
      end
      ST_START: begin
        if (tick_c) begin
          state_d = ST_DATA;
          tx_d    = shift[0];
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_d = shift >> 1;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            state_d   = ST_STOP;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        // The next start bit follows the stop bit with no idle gap.
        if (tick_c) begin
          if (!tdre) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      shift_d   = hold;
      tdre_d    = 1'b1;
      busy_d    = 1'b1;
      tx_d      = 1'b0;
      state_d   = ST_START;
      restart_c = 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: a line monitor decodes frames off tx and checks them
// against a queue of expected bytes filled by the stimulus process.
module tb_midi_uart_tx;

  localparam int MD = 32;

  typedef struct {
    logic [7:0] data;
    int         gap;   // expected idle samples before this frame, -1 = any
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0, wr2 = 1'b0, wr33 = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       tx, tdre, busy, ovr;
  logic       tx2, tdre2, busy2, ovr2;
  logic       tx33, tdre33, busy33, ovr33;
  logic       sel33 = 1'b0;
  logic       txs, tdres, busys, ovrs;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  midi_uart_tx u_dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .ovr_clr(ovr_clr),
    .tx(tx), .tdre(tdre), .busy(busy), .ovr(ovr)
  );

  midi_uart_tx #(.CLK_DIV(2)) u_d2 (
    .clk(clk), .reset(reset), .din(din), .wr(wr2), .ovr_clr(ovr_clr),
    .tx(tx2), .tdre(tdre2), .busy(busy2), .ovr(ovr2)
  );

  midi_uart_tx #(.CLK_DIV(33)) u_d33 (
    .clk(clk), .reset(reset), .din(din), .wr(wr33), .ovr_clr(ovr_clr),
    .tx(tx33), .tdre(tdre33), .busy(busy33), .ovr(ovr33)
  );

  assign txs   = sel33 ? tx33   : tx2;
  assign tdres = sel33 ? tdre33 : tdre2;
  assign busys = sel33 ? busy33 : busy2;
  assign ovrs  = sel33 ? ovr33  : ovr2;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Line monitor: samples tx on falling edges and decodes frames slot by slot.
  int         m_phase = -1;
  int         m_idle = 0;
  int         m_gap = 0;
  int         m_bad = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_val = 1'b1;
  logic       m_stop = 1'b1;
  exp_t       m_exp;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = -1;
      m_idle  = 0;
    end else begin
      if (m_phase < 0) begin
        if (!tx) begin
          m_phase = 0;
          m_gap   = m_idle;
          m_idle  = 0;
          m_bad   = 0;
        end else begin
          m_idle++;
        end
      end
      if (m_phase >= 0) begin
        if (m_phase % MD == 0) m_val = tx;
        else if (tx !== m_val) m_bad++;
        if (m_phase % MD == 0 && m_phase / MD >= 1 && m_phase / MD <= 8)
          m_byte[m_phase / MD - 1] = tx;
        if (m_phase == 9 * MD) m_stop = tx;
        m_phase++;
        if (m_phase == 10 * MD) begin
          m_phase = -1;
          if (sb.size() == 0) begin
            chk("unexpected_frame", int'(m_byte), -1);
          end else begin
            m_exp = sb.pop_front();
            chk("frame_data", int'(m_byte), int'(m_exp.data));
            chk("bit_width", m_bad, 0);
            chk("stop_bit", int'(m_stop), 1);
            if (m_exp.gap >= 0) chk("frame_gap", m_gap, m_exp.gap);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input int gap);
    exp_t e;
    e.data = b;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wr_byte(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    @(posedge clk); #1;
    wr  = 1'b0;
  endtask

  task automatic wait_tdre(input int budget);
    int n = 0;
    while (!tdre && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tdre_wait", int'(tdre), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
  endtask

  task automatic quiet(input string name, input int cycles);
    int viol = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || tdre !== 1'b1 || busy !== 1'b0) viol++;
    end
    @(posedge clk); #1;
    chk(name, viol, 0);
  endtask

  task automatic frame_check(input int d);
    logic [9:0] pat;
    int bad = 0;
    pat = {1'b1, 8'hA5, 1'b0};
    din = 8'hA5;
    if (sel33) wr33 = 1'b1; else wr2 = 1'b1;
    @(posedge clk); #1;
    wr2 = 1'b0;
    wr33 = 1'b0;
    chk("p_tdre_low", int'(tdres), 0);
    @(posedge clk); #1;
    chk("p_start", int'(txs), 0);
    chk("p_busy_rise", int'(busys), 1);
    for (int i = 0; i < 10 * d; i++) begin
      @(negedge clk);
      if (txs !== pat[i / d]) bad++;
    end
    chk("p_bits", bad, 0);
    chk("p_busy_end", int'(busys), 1);
    @(posedge clk); #1;
    chk("p_busy_fall", int'(busys), 0);
    chk("p_tx_idle", int'(txs), 1);
    chk("p_ovr", int'(ovrs), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int viol;
    // Reset state and a long idle stretch.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_tdre", int'(tdre), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(ovr), 0);
    reset = 1'b0;
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tdre !== 1'b1 || busy !== 1'b0 || ovr !== 1'b0) viol++;
    end
    @(posedge clk); #1;
    chk("idle_1000", viol, 0);

    // Single frame: latency and frame length.
    wr_byte(8'h90);
    push(8'h90, -1);
    chk("t2_tdre_low", int'(tdre), 0);
    chk("t2_tx_still_high", int'(tx), 1);
    chk("t2_busy_low", int'(busy), 0);
    @(posedge clk); #1;
    chk("t2_start_tx", int'(tx), 0);
    chk("t2_tdre_back", int'(tdre), 1);
    chk("t2_busy_rise", int'(busy), 1);
    repeat (319) @(posedge clk);
    #1;
    chk("t2_busy_held", int'(busy), 1);
    @(posedge clk); #1;
    chk("t2_busy_fall", int'(busy), 0);
    chk("t2_tx_idle", int'(tx), 1);

    // Three back-to-back frames.
    wr_byte(8'h90);
    push(8'h90, -1);
    wait_tdre(100);
    wr_byte(8'h3C);
    push(8'h3C, 0);
    wait_tdre(1000);
    wr_byte(8'h64);
    push(8'h64, 0);
    chk("t3_ovr_mid", int'(ovr), 0);
    wait_idle(2000);
    chk("t3_ovr_end", int'(ovr), 0);

    // Overrun: second pending write dropped, flag sticky, clear, set-wins.
    wr_byte(8'h90);
    push(8'h90, -1);
    wait_tdre(100);
    wr_byte(8'h3C);
    push(8'h3C, 0);
    chk("t4_ovr_before", int'(ovr), 0);
    wr_byte(8'h64);
    chk("t4_ovr_set", int'(ovr), 1);
    chk("t4_tdre_full", int'(tdre), 0);
    wait_idle(2000);
    chk("t4_ovr_sticky", int'(ovr), 1);
    pulse_clr();
    chk("t4_ovr_clr", int'(ovr), 0);
    wr_byte(8'h11);
    push(8'h11, -1);
    din = 8'h22;
    wr = 1'b1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    ovr_clr = 1'b0;
    chk("t4_set_wins", int'(ovr), 1);
    chk("t4_xfer_tdre", int'(tdre), 1);
    chk("t4_xfer_tx", int'(tx), 0);
    wait_idle(1000);
    pulse_clr();
    chk("t4_ovr_final", int'(ovr), 0);

    // Reset at cycle 150 of a 0xFF frame with a byte pending.
    wr_byte(8'hFF);
    @(posedge clk); #1;
    wr_byte(8'h5A);
    chk("t5_pending", int'(tdre), 0);
    repeat (148) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_tx", int'(tx), 1);
    chk("t5_async_tdre", int'(tdre), 1);
    chk("t5_async_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    quiet("t5_no_residual", 800);

    // Reset during a low start bit must raise tx at once.
    wr_byte(8'h00);
    @(posedge clk);
    repeat (19) @(posedge clk);
    #2;
    chk("t5b_pre_tx", int'(tx), 0);
    reset = 1'b1;
    #1;
    chk("t5b_async_tx", int'(tx), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    quiet("t5b_no_residual", 400);

    // Other divider builds.
    sel33 = 1'b0;
    frame_check(2);
    sel33 = 1'b1;
    frame_check(33);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
